// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Load/store controller in front of a byte-addressed word RAM that
//            has a bidirectional data bus. Byte loads and stores are built
//            when MEM_CTRL_BYTE_ACCESS_EN is defined; byte stores use a
//            read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module mem_ctrl #(
    parameter int ADDR_W = `ADDR_SIZE,
    parameter int DATA_W = `WORD_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
`ifdef MEM_CTRL_BYTE_ACCESS_EN
        S_RMW  = 3'd4,
`endif
        S_RSP  = 3'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                w_bad_req;
`ifdef MEM_CTRL_BYTE_ACCESS_EN
    logic                byte_q, byte_d;

    assign w_bad_req = !req_byte && req_addr[0];
`else
    assign w_bad_req = req_byte || req_addr[0];
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef MEM_CTRL_BYTE_ACCESS_EN
        byte_d  = byte_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
`ifdef MEM_CTRL_BYTE_ACCESS_EN
                    byte_d  = req_byte;
`endif
                    // Rejected requests skip the RAM entirely.
                    if (w_bad_req) begin
                        err_d   = 1'b1;
                        state_d = S_RSP;
                    end else if (!req_we) begin
                        state_d = S_RD;
`ifdef MEM_CTRL_BYTE_ACCESS_EN
                    end else if (req_byte) begin
                        state_d = S_RMW;
`endif
                    end else begin
                        state_d = S_WR;
                    end
                end
            end
            S_RD: begin
`ifdef MEM_CTRL_BYTE_ACCESS_EN
                if (byte_q && addr_q[0])
                    rdata_d = {{(DATA_W-8){1'b0}}, ram_data[DATA_W-1:8]};
                else if (byte_q)
                    rdata_d = {{(DATA_W-8){1'b0}}, ram_data[7:0]};
                else
                    rdata_d = ram_data;
`else
                rdata_d = ram_data;
`endif
                state_d = S_RSP;
            end
`ifdef MEM_CTRL_BYTE_ACCESS_EN
            S_RMW: begin
                // Merge the store byte into the current word (little-endian lanes).
                if (addr_q[0])
                    wdata_d = {wdata_q[7:0], ram_data[7:0]};
                else
                    wdata_d = {ram_data[DATA_W-1:8], wdata_q[7:0]};
                state_d = S_WR;
            end
`endif
            S_WR:    state_d = S_RSP;
            S_RSP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef MEM_CTRL_BYTE_ACCESS_EN
            byte_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef MEM_CTRL_BYTE_ACCESS_EN
            byte_q  <= byte_d;
`endif
        end
    end

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign rsp_valid = (state_q == S_RSP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rdata_q;
    // The RAM only ever sees word-aligned addresses.
    assign ram_addr  = addr_q & ~ADDR_W'(1);
    assign ram_wr_en = (state_q == S_WR) && !rst;
    assign ram_data  = ram_wr_en ? wdata_q : {DATA_W{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Directed vector bench for mem_ctrl with a behavioural word RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;
    localparam int AW = 16;
    localparam int DW = 16;

    typedef struct {
        bit          we;
        bit          byt;
        logic [15:0] addr;
        logic [15:0] wdata;
        bit          err;
        logic [15:0] rdata;
        int          lat;
        int          wr;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_clr = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic          req_byte = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    wire           req_ready, rsp_valid, rsp_err, ram_wr_en;
    wire  [DW-1:0] rsp_rdata;
    wire  [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;

    int n_vec = 0;
    int n_bad = 0;

    logic [DW-1:0] mem [0:(1<<(AW-1))-1];
    wire  [DW-1:0] rd_word = mem[ram_addr[AW-1:1]];

    assign ram_data = ram_wr_en ? {DW{1'bz}} : rd_word;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1<<(AW-1)); i++) mem[i] <= '0;
        end else if (ram_wr_en) begin
            mem[ram_addr[AW-1:1]] <= ram_data;
        end
    end

    mem_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_byte  (req_byte),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_wr_en (ram_wr_en),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outside WR the bus must carry only the RAM's read data; addresses stay even.
    always @(negedge clk) begin
        if (!ram_wr_en && !mem_clr) chk("bus_released", 32'(ram_data), 32'(rd_word));
        if (!mem_clr) chk("addr_even", 32'(ram_addr[0]), 32'd0);
    end

    task automatic run(input vec_t v, input int idx);
        int wr_cnt;
        int lat;
        @(negedge clk);
        chk($sformatf("v%0d.ready", idx), 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_byte  = v.byt;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wr_cnt = 0;
        lat    = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) chk($sformatf("v%0d.busy", idx), 32'(req_ready), 32'd0);
            if (ram_wr_en) wr_cnt++;
            if (rsp_valid) begin
                lat = c;
                break;
            end
        end
        chk($sformatf("v%0d.latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d.err", idx), 32'(rsp_err), 32'(v.err));
        chk($sformatf("v%0d.rdata", idx), 32'(rsp_rdata), 32'(v.rdata));
        chk($sformatf("v%0d.wr_cycles", idx), 32'(wr_cnt), 32'(v.wr));
        if (lat != 0) begin
            @(negedge clk);
            chk($sformatf("v%0d.rsp_one_cycle", idx), 32'(rsp_valid), 32'd0);
        end
    endtask

    vec_t tbl[$];
    vec_t v_rd30;

    initial begin
        //            we    byte  addr      wdata     err   rdata     lat wr
        tbl.push_back('{1'b1, 1'b0, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 2, 1});
        tbl.push_back('{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF, 2, 0});
        tbl.push_back('{1'b0, 1'b0, 16'h0011, 16'h0000, 1'b1, 16'h0000, 1, 0});
        tbl.push_back('{1'b1, 1'b0, 16'h0013, 16'h7777, 1'b1, 16'h0000, 1, 0});
        tbl.push_back('{1'b1, 1'b0, 16'h0020, 16'h1234, 1'b0, 16'h0000, 2, 1});
`ifdef MEM_CTRL_BYTE_ACCESS_EN
        tbl.push_back('{1'b1, 1'b1, 16'h0021, 16'h99AB, 1'b0, 16'h0000, 3, 1});
        tbl.push_back('{1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'hAB34, 2, 0});
        tbl.push_back('{1'b0, 1'b1, 16'h0020, 16'h0000, 1'b0, 16'h0034, 2, 0});
        tbl.push_back('{1'b0, 1'b1, 16'h0021, 16'h0000, 1'b0, 16'h00AB, 2, 0});
        tbl.push_back('{1'b1, 1'b1, 16'h0020, 16'h00CD, 1'b0, 16'h0000, 3, 1});
        tbl.push_back('{1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'hABCD, 2, 0});
`else
        tbl.push_back('{1'b0, 1'b1, 16'h0020, 16'h0000, 1'b1, 16'h0000, 1, 0});
        tbl.push_back('{1'b1, 1'b1, 16'h0021, 16'h00AB, 1'b1, 16'h0000, 1, 0});
        tbl.push_back('{1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h1234, 2, 0});
`endif
        tbl.push_back('{1'b1, 1'b0, 16'hFFFE, 16'h5A5A, 1'b0, 16'h0000, 2, 1});
        tbl.push_back('{1'b0, 1'b0, 16'hFFFE, 16'h0000, 1'b0, 16'h5A5A, 2, 0});
        tbl.push_back('{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 2, 0});

        repeat (2) @(negedge clk);
        chk("rst.ready", 32'(req_ready), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_err", 32'(rsp_err), 32'd0);
        chk("rst.rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst.wr_en", 32'(ram_wr_en), 32'd0);
        chk("rst.ram_addr", 32'(ram_addr), 32'd0);
        rst     = 1'b0;
        mem_clr = 1'b0;

        for (int i = 0; i < tbl.size(); i++) run(tbl[i], i);

        // Reset landing on the WR cycle of a store must abort it without writing.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_byte  = 1'b0;
        req_addr  = 16'h0030;
        req_wdata = 16'hFFFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort.in_wr", 32'(ram_wr_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort.wr_gated", 32'(ram_wr_en), 32'd0);
        @(negedge clk);
        chk("abort.no_rsp0", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort.no_rsp1", 32'(rsp_valid), 32'd0);
        v_rd30 = '{1'b0, 1'b0, 16'h0030, 16'h0000, 1'b0, 16'h0000, 2, 0};
        run(v_rd30, 99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
